// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OWN   = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam int TB_MAX_MASTERS = 16;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tri_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module tri_rr_pick
    import tri_bus_pkg::*;
#(
    parameter int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                win[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter driving one-hot tristate buffer enables with notice and turnaround cycles.
// Optional owner preemption after MAX_HOLD cycles is enabled by defining TRI_ARB_PREEMPT_EN.
//
// state | meaning
// IDLE  | bus free, arbitrate among requests
// SETUP | grant notice to winner, buffers still off
// OWN   | winner drives the bus (en == gnt)
// DRAIN | all buffers off for TURNAROUND cycles
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N_MASTERS  = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 8,
    localparam int IW = idx_width(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] gnt,
    output logic [N_MASTERS-1:0] en,
    output logic [IW-1:0]        owner,
    output logic                 bus_busy
);

    if (N_MASTERS < 2 || N_MASTERS > TB_MAX_MASTERS || TURNAROUND < 1 || TURNAROUND > 7
        || MAX_HOLD < 2) begin : g_param_err
        $error("tri_bus_arbiter: parameter out of range");
    end

    arb_state_t           state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        nxt_ptr;
    logic [IW-1:0]        pick_idx;
    logic [N_MASTERS-1:0] pick_win;
    logic                 pick_any;
    logic [2:0]           dcnt;
    logic                 release_own;

    tri_rr_pick #(.N(N_MASTERS)) u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign nxt_ptr = (owner == IW'(N_MASTERS - 1)) ? '0 : owner + 1'b1;

`ifdef TRI_ARB_PREEMPT_EN
    localparam int HW = idx_width(MAX_HOLD);
    logic [HW-1:0] hold_cnt;

    // Preempt only when someone else is actually waiting.
    assign release_own = !req[owner]
                       || ((hold_cnt == HW'(MAX_HOLD - 1)) && ((req & ~gnt) != '0));
`else
    assign release_own = !req[owner];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            en       <= '0;
            owner    <= '0;
            bus_busy <= 1'b0;
            ptr      <= '0;
            dcnt     <= '0;
`ifdef TRI_ARB_PREEMPT_EN
            hold_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt      <= pick_win;
                        owner    <= pick_idx;
                        bus_busy <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (req[owner]) begin
                        en    <= gnt;
                        state <= OWN;
`ifdef TRI_ARB_PREEMPT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        // Aborted grant still rotates priority away from this master.
                        gnt   <= '0;
                        ptr   <= nxt_ptr;
                        dcnt  <= 3'(TURNAROUND - 1);
                        state <= DRAIN;
                    end
                end
                OWN: begin
                    if (release_own) begin
                        gnt   <= '0;
                        en    <= '0;
                        ptr   <= nxt_ptr;
                        dcnt  <= 3'(TURNAROUND - 1);
                        state <= DRAIN;
                    end
`ifdef TRI_ARB_PREEMPT_EN
                    else if (hold_cnt != HW'(MAX_HOLD - 1)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (dcnt == 3'd0) begin
                        bus_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
